// File: rtl/icache_2way_if.sv
// Fetch-side bus of the two-way instruction cache: lookup, fill, flush and status.
interface icache_2way_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cache_query;
  logic [ADDR_W-1:0] query_addr;
  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              flush_req;
  logic              hit_o;
  logic [DATA_W-1:0] data_o;
  logic              busy_o;
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;

  modport master (
    output cache_query, query_addr, fill_en, fill_addr, fill_data, flush_req,
    input  hit_o, data_o, busy_o, hit_cnt_o, miss_cnt_o
  );

  modport slave (
    input  cache_query, query_addr, fill_en, fill_addr, fill_data, flush_req,
    output hit_o, data_o, busy_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache: registered lookup, true-LRU
// replacement, set-walking invalidate after reset or flush_req.
// Optional hit/miss statistics counters: define ICACHE_STATS_EN.
module icache_2way #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 7,
  parameter int unsigned TAG_W   = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  icache_2way_if.slave bus
);

  localparam int unsigned SETS = 1 << INDEX_W;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Per-set storage, not reset: the invalidate walk clears valid and LRU.
  logic              r_valid0 [SETS];
  logic              r_valid1 [SETS];
  logic [TAG_W-1:0]  r_tag0   [SETS];
  logic [TAG_W-1:0]  r_tag1   [SETS];
  logic [DATA_W-1:0] r_data0  [SETS];
  logic [DATA_W-1:0] r_data1  [SETS];
  logic              r_lru    [SETS];

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [INDEX_W-1:0] r_set_cnt;
  logic [INDEX_W-1:0] w_set_cnt_nxt;
  logic               r_hit;
  logic [DATA_W-1:0]  r_data;

  logic               w_run;
  logic [INDEX_W-1:0] w_q_idx;
  logic [TAG_W-1:0]   w_q_tag;
  logic               w_q_hit0;
  logic               w_q_hit1;
  logic               w_q_act;
  logic [INDEX_W-1:0] w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic               w_f_match0;
  logic               w_f_match1;
  logic               w_f_act;
  logic               w_f_way;
  logic               w_unused;

  // Address split and tag compare for both ports.
  assign w_run      = (r_state == ST_RUN);
  assign w_q_idx    = bus.query_addr[INDEX_W+1:2];
  assign w_q_tag    = bus.query_addr[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_q_hit0   = r_valid0[w_q_idx] && (r_tag0[w_q_idx] == w_q_tag);
  assign w_q_hit1   = r_valid1[w_q_idx] && (r_tag1[w_q_idx] == w_q_tag);
  assign w_q_act    = w_run && bus.cache_query;
  assign w_f_idx    = bus.fill_addr[INDEX_W+1:2];
  assign w_f_tag    = bus.fill_addr[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_f_match0 = r_valid0[w_f_idx] && (r_tag0[w_f_idx] == w_f_tag);
  assign w_f_match1 = r_valid1[w_f_idx] && (r_tag1[w_f_idx] == w_f_tag);
  assign w_f_act    = w_run && bus.fill_en;
  assign w_unused   = ^{bus.query_addr, bus.fill_addr};

  // Fill victim: matching way, then invalid way 0, invalid way 1, else LRU way.
  always_comb begin
    w_f_way = r_lru[w_f_idx];
    if (w_f_match0)             w_f_way = 1'b0;
    else if (w_f_match1)        w_f_way = 1'b1;
    else if (!r_valid0[w_f_idx]) w_f_way = 1'b0;
    else if (!r_valid1[w_f_idx]) w_f_way = 1'b1;
  end

  // Next-state logic: RUN <-> FLUSH with the set walk counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_set_cnt_nxt = r_set_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.flush_req) begin
          w_state_nxt   = ST_FLUSH;
          w_set_cnt_nxt = '0;
        end
      end
      ST_FLUSH: begin
        w_set_cnt_nxt = r_set_cnt + INDEX_W'(1);
        if (r_set_cnt == INDEX_W'(SETS - 1)) begin
          w_state_nxt   = ST_RUN;
          w_set_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_FLUSH;
        w_set_cnt_nxt = '0;
      end
    endcase
  end

  // State register; reset restarts the walk at set 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_FLUSH;
      r_set_cnt <= '0;
    end else if (rdy) begin
      r_state   <= w_state_nxt;
      r_set_cnt <= w_set_cnt_nxt;
    end
  end

  // Registered lookup result; misses and idle cycles return zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit  <= 1'b0;
      r_data <= '0;
    end else if (rdy) begin
      r_hit  <= w_q_act && (w_q_hit0 || w_q_hit1);
      if (w_q_act && w_q_hit0)      r_data <= r_data0[w_q_idx];
      else if (w_q_act && w_q_hit1) r_data <= r_data1[w_q_idx];
      else                          r_data <= '0;
    end
  end

  // Array updates: walk clear, lookup LRU touch, then fill (fill LRU wins).
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      if (r_state == ST_FLUSH) begin
        r_valid0[r_set_cnt] <= 1'b0;
        r_valid1[r_set_cnt] <= 1'b0;
        r_lru[r_set_cnt]    <= 1'b0;
      end else begin
        if (w_q_act && w_q_hit0)      r_lru[w_q_idx] <= 1'b1;
        else if (w_q_act && w_q_hit1) r_lru[w_q_idx] <= 1'b0;
        if (w_f_act) begin
          if (!w_f_way) begin
            r_valid0[w_f_idx] <= 1'b1;
            r_tag0[w_f_idx]   <= w_f_tag;
            r_data0[w_f_idx]  <= bus.fill_data;
          end else begin
            r_valid1[w_f_idx] <= 1'b1;
            r_tag1[w_f_idx]   <= w_f_tag;
            r_data1[w_f_idx]  <= bus.fill_data;
          end
          r_lru[w_f_idx] <= !w_f_way;
        end
      end
    end
  end

  assign bus.hit_o  = r_hit;
  assign bus.data_o = r_data;
  assign bus.busy_o = (r_state == ST_FLUSH);

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Hit/miss statistics for RUN-state queries; survive flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy && w_q_act) begin
      if (w_q_hit0 || w_q_hit1) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else                      r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.hit_cnt_o  = r_hit_cnt;
  assign bus.miss_cnt_o = r_miss_cnt;
`else
  assign bus.hit_cnt_o  = '0;
  assign bus.miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Directed self-checking bench for icache_2way.
module tb_icache_2way;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;
  int   n;

  icache_2way_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  icache_2way dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    bus.fill_en   = 1'b1;
    bus.fill_addr = addr;
    bus.fill_data = data;
    tick();
    bus.fill_en   = 1'b0;
  endtask

  task automatic query(input string tag, input logic [31:0] addr,
                       input logic exp_hit, input logic [31:0] exp_data);
    bus.cache_query = 1'b1;
    bus.query_addr  = addr;
    tick();
    bus.cache_query = 1'b0;
    check({tag, "_hit"}, {31'b0, bus.hit_o}, {31'b0, exp_hit});
    check({tag, "_data"}, bus.data_o, exp_data);
    if (exp_hit) exp_hits++;
    else         exp_miss++;
  endtask

  // Counts busy cycles of one walk, optionally injecting a fill, a query or a 5-cycle rdy hold.
  task automatic walk(input int fill_at, input int query_at, input int hold_at, output int cycles);
    cycles = 0;
    while (bus.busy_o && cycles < 400) begin
      bus.fill_en     = (cycles == fill_at);
      bus.fill_addr   = 32'h0000_0100;
      bus.fill_data   = 32'h0BAD_0BAD;
      bus.cache_query = (cycles == query_at);
      bus.query_addr  = 32'h0000_0100;
      rdy = !(hold_at >= 0 && cycles >= hold_at && cycles < hold_at + 5);
      tick();
      if (cycles == query_at) check("walk_query_miss", {31'b0, bus.hit_o}, 32'd0);
      cycles++;
    end
    bus.fill_en     = 1'b0;
    bus.cache_query = 1'b0;
    rdy             = 1'b1;
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef ICACHE_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    bus.cache_query = 1'b0;
    bus.query_addr  = '0;
    bus.fill_en     = 1'b0;
    bus.fill_addr   = '0;
    bus.fill_data   = '0;
    bus.flush_req   = 1'b0;
    repeat (3) tick();
    check("rst_hit",  {31'b0, bus.hit_o}, 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_busy", {31'b0, bus.busy_o}, 32'd1);
    check("rst_hcnt", bus.hit_cnt_o, 32'd0);
    check("rst_mcnt", bus.miss_cnt_o, 32'd0);

    // Release, then re-assert reset mid-walk: the walk restarts from set 0.
    rst = 1'b1;
    repeat (50) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    walk(-1, -1, -1, n);
    check("reset_busy_len", 32'(n), 32'd128);

    query("q0_cold", 32'h0000_0000, 1'b0, 32'h0);

    fill(32'h0000_0100, 32'hDEAD_BEEF);
    query("q100", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
    tick();
    check("idle_hit",  {31'b0, bus.hit_o}, 32'd0);
    check("idle_data", bus.data_o, 32'd0);

    // Eviction in set 0x40: A tag 0, B tag 1, C tag 2.
    fill(32'h0000_0100, 32'hDEAD_BEEF);
    fill(32'h0000_0300, 32'hBBBB_0001);
    query("evict_qA", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
    fill(32'h0000_0500, 32'hCCCC_0002);
    query("evict_B", 32'h0000_0300, 1'b0, 32'h0);
    query("evict_A", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
    query("evict_C", 32'h0000_0500, 1'b1, 32'hCCCC_0002);

    // Flush with a fill and query during the walk, after set 0x40 is cleared.
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("flush_busy", {31'b0, bus.busy_o}, 32'd1);
    walk(100, 110, -1, n);
    check("flush_busy_len", 32'(n), 32'd128);
    query("post_flush", 32'h0000_0100, 1'b0, 32'h0);

    // Same-cycle query of A and fill of 0x300 into set 0x40.
    fill(32'h0000_0100, 32'hDEAD_BEEF);
    bus.cache_query = 1'b1;
    bus.query_addr  = 32'h0000_0100;
    bus.fill_en     = 1'b1;
    bus.fill_addr   = 32'h0000_0300;
    bus.fill_data   = 32'h3333_0003;
    tick();
    bus.cache_query = 1'b0;
    bus.fill_en     = 1'b0;
    check("same_hit",  {31'b0, bus.hit_o}, 32'd1);
    check("same_data", bus.data_o, 32'hDEAD_BEEF);
    exp_hits++;
    // Fill LRU won (LRU = way 0), so the next new tag evicts A, not 0x300.
    fill(32'h0000_0500, 32'h5555_0005);
    query("lru_A",   32'h0000_0100, 1'b0, 32'h0);
    query("lru_300", 32'h0000_0300, 1'b1, 32'h3333_0003);
    query("lru_500", 32'h0000_0500, 1'b1, 32'h5555_0005);

    // rdy=0 after a hit freezes outputs and drops the fill/query.
    query("pre_hold", 32'h0000_0300, 1'b1, 32'h3333_0003);
    rdy = 1'b0;
    bus.cache_query = 1'b1;
    bus.query_addr  = 32'h0000_0700;
    bus.fill_en     = 1'b1;
    bus.fill_addr   = 32'h0000_0700;
    bus.fill_data   = 32'h7777_0007;
    repeat (5) tick();
    check("hold_hit",  {31'b0, bus.hit_o}, 32'd1);
    check("hold_data", bus.data_o, 32'h3333_0003);
    check("hold_busy", {31'b0, bus.busy_o}, 32'd0);
    rdy = 1'b1;
    bus.cache_query = 1'b0;
    bus.fill_en     = 1'b0;
    query("post_hold_500", 32'h0000_0500, 1'b1, 32'h5555_0005);
    query("post_hold_700", 32'h0000_0700, 1'b0, 32'h0);
    check("mid_hcnt", bus.hit_cnt_o,  stat_exp(exp_hits));
    check("mid_mcnt", bus.miss_cnt_o, stat_exp(exp_miss));

    // Flush with a 5-cycle rdy hold mid-walk; counters survive the flush.
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    walk(-1, -1, 30, n);
    check("hold_busy_len", 32'(n), 32'd133);
    query("post_flush2", 32'h0000_0300, 1'b0, 32'h0);
    check("end_hcnt", bus.hit_cnt_o,  stat_exp(exp_hits));
    check("end_mcnt", bus.miss_cnt_o, stat_exp(exp_miss));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_2way.md
# icache_2way

Parametrised two-way set-associative instruction cache with registered lookup, true-LRU replacement and a set-walking invalidate engine. It sits between the instruction-fetch stage and the memory controller, replacing the direct-mapped instruction cache. Hits return the instruction word one cycle after the query; misses are refilled by the fetch/memory path through the fill port.

## Interface
- `ADDR_W`, 32: instruction address width.
- `DATA_W`, 32: instruction word width.
- `INDEX_W`, 7: set index bits; SETS = 2^INDEX_W.
- `TAG_W`, 9: tag bits; requires INDEX_W+TAG_W+2 <= ADDR_W.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `rdy` in 1: global ready; 0 freezes all state and outputs.
- `cache_query` in 1: lookup request this cycle.
- `query_addr` in ADDR_W: lookup address.
- `fill_en` in 1: write one word into the cache.
- `fill_addr` in ADDR_W: fill address.
- `fill_data` in DATA_W: fill word.
- `flush_req` in 1: start full invalidate, single-cycle pulse.
- `hit_o` out 1: registered hit for previous-cycle query.
- `data_o` out DATA_W: registered hit word, 0 on miss.
- `busy_o` out 1: invalidate walk in progress.
- `hit_cnt_o`, `miss_cnt_o` out 32: statistics counters (see Configuration).

## Operation
- Address split: index = addr[INDEX_W+1:2], tag = addr[INDEX_W+TAG_W+1:INDEX_W+2]; bits [1:0] ignored.
- Per set: 2 ways of {valid, tag, data}, plus 1 LRU bit naming the least-recently-used way.
- FSM states:
  - RUN: normal operation.
  - FLUSH: set_cnt walks 0..SETS-1, clearing both valid bits and the LRU bit of one set per cycle. FLUSH to RUN after set SETS-1 is cleared.
- Reset: state = FLUSH, set_cnt = 0. Arrays are not reset directly (RAM-inferable); the walk clears them.
- RUN plus flush_req enters FLUSH with set_cnt = 0. flush_req in FLUSH is ignored.
- Lookup (RUN, cache_query=1): compare tag against both valid ways.
  - Hit: hit_o=1, data_o = way data, LRU = other way.
  - Miss: hit_o=0, data_o=0.
  - A tag match in both ways cannot occur; if it does, way 0 wins.
- Fill (RUN, fill_en=1), target way chosen in this order:
  - the way already holding the tag;
  - else invalid way 0;
  - else invalid way 1;
  - else the LRU way.
  - Writes valid=1, tag and data; LRU = other way.
- In FLUSH: queries return miss; fills are dropped.
- Query and fill in the same cycle:
  - Lookup reads pre-fill contents (read-before-write).
  - If both touch the same set, the fill's LRU update wins.
- rdy=0: no array, LRU, FSM, counter or output register changes.

## Timing
- Reset values: hit_o=0, data_o=0, busy_o=1, counters 0, state FLUSH.
- Query sampled at edge N; hit_o/data_o valid from N until edge N+1. Cycles with no query give hit_o=0, data_o=0.
- Fill at edge N is visible to a query sampled at edge N+1.
- busy_o is high for exactly SETS rdy-qualified cycles after reset release or after a flush_req.
- Reset asserted mid-walk restarts the walk at set 0.

## Configuration
- `ICACHE_STATS_EN`, defined:
  - hit_cnt_o increments on each RUN query hit; miss_cnt_o increments on each RUN query miss.
  - Counters are 32-bit, wrap at 2^32, clear on reset, do not clear on flush.
- Undefined: both outputs tied to 0 and no counter logic is synthesised.

## Test plan
- Release reset (defaults): busy_o=1 for 128 cycles, then 0. Query 0x0000_0000 -> hit_o=0, data_o=0.
- Fill 0x100 with 0xDEADBEEF; query 0x100 next cycle -> one cycle later hit_o=1, data_o=0xDEADBEEF.
- Eviction, all in set 0x40:
  - Fill A=0x100 (tag 0) and B=0x300 (tag 1); query A; fill C=0x500 (tag 2).
  - Expect: B misses; A and C hit with their data.
- Flush:
  - Pulse flush_req -> busy_o=1 for 128 cycles.
  - A fill of 0x100 during the walk is dropped.
  - After the walk, query 0x100 -> miss.
- Same-set, same-cycle query/fill:
  - Set 0x40 holds A. In one cycle, query A and fill 0x300.
  - Expect: the query hits with A's data; the fill lands in the other way; a query of 0x300 next cycle -> hit.
- Hold rdy=0 for 5 cycles mid-walk and after a hit:
  - busy_o duration extends by 5.
  - hit_o/data_o hold their values.
  - With ICACHE_STATS_EN, counters match the issued hits and misses exactly.
